// File: rtl/coin_validator.sv
// Coin-chute front end: synchronises and debounces two coin sensors, measures
// the filtered pulse width and emits one registered credit code or reject pulse per coin.
module coin_validator #(
    parameter int DEBOUNCE  = 4,
    parameter int MIN_WIDTH = 8,
    parameter int MAX_WIDTH = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sense_50,
    input  logic       sense_100,
    input  logic       inhibit,
    output logic [1:0] x,
    output logic       reject
);
    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int WW = $clog2(MAX_WIDTH + 2);
    localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE - 1);
    localparam logic [WW-1:0] MIN_W    = WW'(MIN_WIDTH);
    localparam logic [WW-1:0] MAX_W    = WW'(MAX_WIDTH);
    localparam logic [WW-1:0] JAM_W    = WW'(MAX_WIDTH + 1);
    localparam logic [WW-1:0] ONE_W    = WW'(1);

    // Bit 0 is the 50-cent chute, bit 1 the 1-euro chute.
    logic [1:0] sense_raw;
    logic [1:0] filt;
    logic [1:0] rise;

    assign sense_raw = {sense_100, sense_50};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            logic          sync1_reg;
            logic          sync2_reg;
            logic          filt_reg;
            logic          filt_d_reg;
            logic [CW-1:0] cnt_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync1_reg  <= 1'b0;
                    sync2_reg  <= 1'b0;
                    filt_reg   <= 1'b0;
                    filt_d_reg <= 1'b0;
                    cnt_reg    <= '0;
                end else begin
                    sync1_reg  <= sense_raw[gi];
                    sync2_reg  <= sync1_reg;
                    filt_d_reg <= filt_reg;
                    // Rising and falling edges take the same number of samples,
                    // so a filtered pulse keeps the width of the raw one.
                    if (sync2_reg == filt_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == DB_LAST) begin
                        filt_reg <= sync2_reg;
                        cnt_reg  <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end

            assign filt[gi] = filt_reg;
            assign rise[gi] = filt_reg & ~filt_d_reg;
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, MEASURE, DRAIN} state_t;

    state_t        state_reg, state_next;
    logic [WW-1:0] width_reg, width_next;
    logic          coin_reg, coin_next;
    logic          invalid_reg, invalid_next;
    logic [1:0]    x_reg, x_next;
    logic          reject_reg, reject_next;

    logic own_level;
    logic other_level;
    logic bad_coin;

    assign own_level   = coin_reg ? filt[1] : filt[0];
    assign other_level = coin_reg ? filt[0] : filt[1];
    assign bad_coin    = invalid_reg | other_level;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            width_reg   <= '0;
            coin_reg    <= 1'b0;
            invalid_reg <= 1'b0;
            x_reg       <= 2'b00;
            reject_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            width_reg   <= width_next;
            coin_reg    <= coin_next;
            invalid_reg <= invalid_next;
            x_reg       <= x_next;
            reject_reg  <= reject_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        width_next   = width_reg;
        coin_next    = coin_reg;
        invalid_next = invalid_reg;
        x_next       = 2'b00;
        reject_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (rise == 2'b11) begin
                    reject_next = 1'b1;
                    state_next  = DRAIN;
                end else if (rise != 2'b00) begin
                    state_next   = MEASURE;
                    coin_next    = rise[1];
                    width_next   = ONE_W;
                    invalid_next = 1'b0;
                end
            end
            MEASURE: begin
                invalid_next = bad_coin;
                if (!own_level) begin
                    // inhibit only matters in the cycle the coin leaves the sensor
                    if (width_reg >= MIN_W && width_reg <= MAX_W && !bad_coin && !inhibit) begin
                        x_next = coin_reg ? 2'b10 : 2'b01;
                    end else begin
                        reject_next = 1'b1;
                    end
                    state_next = IDLE;
                    width_next = '0;
                end else if (width_reg == JAM_W) begin
                    reject_next = 1'b1;
                    state_next  = DRAIN;
                    width_next  = '0;
                end else begin
                    width_next = width_reg + 1'b1;
                end
            end
            DRAIN: begin
                if (filt == 2'b00) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign x      = x_reg;
    assign reject = reject_reg;

endmodule
